dispenser_ctrl: RTL and testbench

Sequencing controller for the product dispenser: latches a product selection, accumulates coin credit, drives the selected dispense motor for a fixed number of cycles, then pays out change one unit per cycle. It sits between the front-panel inputs (selection buttons, coin acceptor, cancel) and the dispenser actuators. All of its state lives in registers with synchronous reset.

---
 rtl/dispenser_pkg.sv | 7 +
 rtl/dispenser_if.sv | 18 +
 rtl/dispenser_state_reg.sv | 9 +
 rtl/dispenser_ctrl.sv | 70 +++++++
 tb/tb_dispenser_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/dispenser_pkg.sv
// dispenser_pkg: shared state encodings and default widths for the dispenser controller.
package dispenser_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, PAY = 3'd1, DISPENSE = 3'd2, CHANGE = 3'd3} state_t;
  localparam int DEF_CREDIT_W = 6;
  localparam int COIN_W = 4;
  localparam int N_PROD = 4;
endpackage

// File: rtl/dispenser_if.sv
// dispenser_if: front-panel inputs and actuator outputs of the dispenser controller.
interface dispenser_if import dispenser_pkg::*; #(parameter int CREDIT_W = DEF_CREDIT_W);
  logic sel_valid;
  logic [1:0] sel;
  logic coin_valid;
  logic [COIN_W-1:0] coin_val;
  logic cancel;
  logic [N_PROD-1:0] dispense;
  logic change_pulse;
  logic coin_reject;
  logic busy;
  logic [CREDIT_W-1:0] credit;
  logic [2:0] state;
  modport master(output sel_valid, sel, coin_valid, coin_val, cancel,
                 input dispense, change_pulse, coin_reject, busy, credit, state);
  modport slave(input sel_valid, sel, coin_valid, coin_val, cancel,
                output dispense, change_pulse, coin_reject, busy, credit, state);
endinterface

// File: rtl/dispenser_state_reg.sv
// dispenser_state_reg: W-bit D register cleared by synchronous active-low reset.
module dispenser_state_reg #(parameter int W = 1) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= reset_n ? d : '0;
endmodule

// File: rtl/dispenser_ctrl.sv
// dispenser_ctrl: selection latch, coin credit, timed motor drive and unit-by-unit change payout.
module dispenser_ctrl import dispenser_pkg::*; #(
  parameter int PRICE0 = 5,
  parameter int PRICE1 = 10,
  parameter int PRICE2 = 15,
  parameter int PRICE3 = 20,
  parameter int DISP_CYCLES = 4,
  parameter int TIMEOUT = 255,
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input logic clk,
  input logic reset_n,
  dispenser_if.slave bus
);
  localparam int CNT_W = $clog2((TIMEOUT > DISP_CYCLES ? TIMEOUT : DISP_CYCLES) + 1);
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'((1 << CREDIT_W) - 1);
  logic [2:0] st_q, st_d;
  logic [CREDIT_W-1:0] cr_q, cr_d, price;
  logic [1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CREDIT_W:0] sum;
  logic coin, leave, accept;
  state_t st, nxt;
  dispenser_state_reg #(.W(3)) u_st (.clk, .reset_n, .d(st_d), .q(st_q));
  dispenser_state_reg #(.W(CREDIT_W)) u_cr (.clk, .reset_n, .d(cr_d), .q(cr_q));
  dispenser_state_reg #(.W(2)) u_sel (.clk, .reset_n, .d(sel_d), .q(sel_q));
  dispenser_state_reg #(.W(CNT_W)) u_cnt (.clk, .reset_n, .d(cnt_d), .q(cnt_q));
  always_comb price = sel_q == 2'd0 ? CREDIT_W'(PRICE0) : sel_q == 2'd1 ? CREDIT_W'(PRICE1) :
                      sel_q == 2'd2 ? CREDIT_W'(PRICE2) : CREDIT_W'(PRICE3);
  // A coin is only taken when PAY stays put this cycle, so exits never swallow credit.
  always_comb begin
    st = st_q[2] ? IDLE : state_t'(st_q);
    coin = bus.coin_valid && bus.coin_val != '0;
    sum = {1'b0, cr_q} + (CREDIT_W+1)'(bus.coin_val);
    leave = cr_q >= price || bus.cancel || cnt_q == CNT_W'(TIMEOUT);
    accept = st == PAY && coin && sum <= MAXC && !leave;
    nxt = st;
    cr_d = cr_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    case (st)
      IDLE: if (bus.sel_valid) begin
        nxt = PAY;
        sel_d = bus.sel;
        cnt_d = '0;
      end
      PAY: if (cr_q >= price) begin
        nxt = DISPENSE;
        cr_d = cr_q - price;
        cnt_d = '0;
      end else if (bus.cancel || cnt_q == CNT_W'(TIMEOUT)) nxt = CHANGE;
      else if (accept) begin
        cr_d = sum[CREDIT_W-1:0];
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      DISPENSE: if (cnt_q == CNT_W'(DISP_CYCLES - 1)) nxt = CHANGE;
      else cnt_d = cnt_q + 1'b1;
      CHANGE: if (cr_q != '0) cr_d = cr_q - 1'b1;
      else nxt = IDLE;
      default: nxt = IDLE;
    endcase
    st_d = nxt;
  end
  assign bus.coin_reject = coin && !accept;
  assign bus.dispense = st == DISPENSE ? 4'b0001 << sel_q : 4'b0000;
  assign bus.change_pulse = st == CHANGE && cr_q != '0;
  assign bus.busy = st != IDLE;
  assign bus.credit = cr_q;
  assign bus.state = st;
endmodule

// File: tb/tb_dispenser_ctrl.sv
// tb_dispenser_ctrl: directed scenario tasks with hand-computed expectations.
module tb_dispenser_ctrl;
  logic clk = 0;
  logic reset_n = 0;
  int total = 0;
  int passed = 0;
  dispenser_if #(.CREDIT_W(6)) bus();
  dispenser_ctrl #(.PRICE3(63), .TIMEOUT(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.sel_valid = 0; bus.sel = 0; bus.coin_valid = 0; bus.coin_val = 0; bus.cancel = 0;
  endtask

  task automatic coin(input logic [3:0] v);
    bus.coin_valid = 1; bus.coin_val = v;
  endtask

  task automatic start(input logic [1:0] s);
    clr(); bus.sel_valid = 1; bus.sel = s;
    cyc();
    clr();
  endtask

  task automatic test_reset();
    clr(); reset_n = 0;
    cyc(); cyc();
    reset_n = 1; #1;
    total++; if ({bus.state, bus.credit, bus.busy, bus.dispense, bus.change_pulse} !== 15'd0)
      $display("FAIL reset: got %b want 0", {bus.state, bus.credit, bus.busy, bus.dispense, bus.change_pulse}); else passed++;
  endtask

  task automatic test_exact();
    int pulses = 0;
    start(2'd1);
    total++; if (bus.state !== 3'd1 || bus.busy !== 1'b1) $display("FAIL exact_pay_entry: state %0d busy %b want 1 1", bus.state, bus.busy); else passed++;
    coin(4'd5); cyc(); coin(4'd5); cyc(); clr();
    total++; if (bus.credit !== 6'd10 || bus.state !== 3'd1) $display("FAIL exact_credit: credit %0d state %0d want 10 1", bus.credit, bus.state); else passed++;
    cyc();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dispense !== 4'b0010 || bus.state !== 3'd2) $display("FAIL exact_dispense[%0d]: %b state %0d want 0010 2", i, bus.dispense, bus.state); else passed++;
      cyc();
    end
    total++; if (bus.state !== 3'd3 || bus.change_pulse !== 1'b0 || bus.dispense !== 4'd0) $display("FAIL exact_change: state %0d pulse %b want 3 0", bus.state, bus.change_pulse); else passed++;
    cyc();
    total++; if (bus.state !== 3'd0 || bus.busy !== 1'b0) $display("FAIL exact_idle: state %0d busy %b want 0 0", bus.state, bus.busy); else passed++;
  endtask

  task automatic test_overpay();
    start(2'd0);
    coin(4'd10); bus.sel_valid = 1; bus.sel = 2'd3; #1;
    total++; if (bus.coin_reject !== 1'b0) $display("FAIL overpay_accept: reject %b want 0", bus.coin_reject); else passed++;
    cyc(); clr();
    total++; if (bus.credit !== 6'd10) $display("FAIL overpay_credit: %0d want 10", bus.credit); else passed++;
    cyc();
    total++; if (bus.credit !== 6'd5 || bus.state !== 3'd2) $display("FAIL overpay_deduct: credit %0d state %0d want 5 2", bus.credit, bus.state); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dispense !== 4'b0001) $display("FAIL overpay_dispense[%0d]: %b want 0001", i, bus.dispense); else passed++;
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.change_pulse !== 1'b1 || bus.credit !== 6'(5 - i)) $display("FAIL overpay_change[%0d]: pulse %b credit %0d want 1 %0d", i, bus.change_pulse, bus.credit, 5 - i); else passed++;
      cyc();
    end
    total++; if (bus.change_pulse !== 1'b0 || bus.credit !== 6'd0 || bus.state !== 3'd3) $display("FAIL overpay_last: pulse %b credit %0d state %0d want 0 0 3", bus.change_pulse, bus.credit, bus.state); else passed++;
    cyc();
    total++; if (bus.state !== 3'd0) $display("FAIL overpay_idle: state %0d want 0", bus.state); else passed++;
  endtask

  task automatic test_cancel();
    int pulses = 0;
    start(2'd3);
    coin(4'd10); cyc(); coin(4'd5); cyc();
    coin(4'd5); bus.cancel = 1; #1;
    total++; if (bus.coin_reject !== 1'b1) $display("FAIL cancel_coin_reject: %b want 1", bus.coin_reject); else passed++;
    cyc(); clr();
    total++; if (bus.state !== 3'd3 || bus.credit !== 6'd15) $display("FAIL cancel_change: state %0d credit %0d want 3 15", bus.state, bus.credit); else passed++;
    for (int i = 0; i < 30 && bus.state == 3'd3; i++) begin
      if (bus.change_pulse) pulses++;
      total++; if (bus.dispense !== 4'd0) $display("FAIL cancel_no_dispense: %b want 0000", bus.dispense); else passed++;
      cyc();
    end
    total++; if (pulses != 15 || bus.state !== 3'd0) $display("FAIL cancel_refund: pulses %0d state %0d want 15 0", pulses, bus.state); else passed++;
  endtask

  task automatic test_saturation();
    start(2'd3);
    for (int i = 0; i < 4; i++) begin coin(4'd15); cyc(); end
    coin(4'd5); #1;
    total++; if (bus.credit !== 6'd60 || bus.coin_reject !== 1'b1) $display("FAIL sat_reject: credit %0d reject %b want 60 1", bus.credit, bus.coin_reject); else passed++;
    cyc();
    total++; if (bus.credit !== 6'd60) $display("FAIL sat_hold: credit %0d want 60", bus.credit); else passed++;
    coin(4'd3); #1;
    total++; if (bus.coin_reject !== 1'b0) $display("FAIL sat_fill: reject %b want 0", bus.coin_reject); else passed++;
    cyc(); clr();
    total++; if (bus.credit !== 6'd63) $display("FAIL sat_max: credit %0d want 63", bus.credit); else passed++;
    cyc();
    coin(4'd7); #1;
    total++; if (bus.state !== 3'd2 || bus.dispense !== 4'b1000 || bus.coin_reject !== 1'b1) $display("FAIL disp_coin_reject: state %0d disp %b reject %b want 2 1000 1", bus.state, bus.dispense, bus.coin_reject); else passed++;
    cyc(); clr();
    total++; if (bus.credit !== 6'd0) $display("FAIL disp_credit: %0d want 0", bus.credit); else passed++;
    for (int i = 0; i < 10 && bus.state != 3'd0; i++) cyc();
    coin(4'd5); #1;
    total++; if (bus.state !== 3'd0 || bus.coin_reject !== 1'b1) $display("FAIL idle_coin_reject: state %0d reject %b want 0 1", bus.state, bus.coin_reject); else passed++;
    cyc(); clr();
    total++; if (bus.credit !== 6'd0 || bus.state !== 3'd0) $display("FAIL idle_coin_credit: credit %0d state %0d want 0 0", bus.credit, bus.state); else passed++;
  endtask

  task automatic test_timeout();
    int n = 0;
    start(2'd2);
    while (bus.state == 3'd1 && n < 20) begin n++; cyc(); end
    total++; if (n != 9 || bus.state !== 3'd3) $display("FAIL timeout: pay cycles %0d state %0d want 9 3", n, bus.state); else passed++;
    cyc();
    total++; if (bus.state !== 3'd0) $display("FAIL timeout_idle: state %0d want 0", bus.state); else passed++;
  endtask

  task automatic test_reset_mid();
    start(2'd0);
    coin(4'd10); cyc(); clr(); cyc(); cyc();
    total++; if (bus.state !== 3'd2 || bus.credit !== 6'd5) $display("FAIL mid_pre: state %0d credit %0d want 2 5", bus.state, bus.credit); else passed++;
    reset_n = 0; cyc(); reset_n = 1; #1;
    total++; if (bus.dispense !== 4'd0 || bus.credit !== 6'd0 || bus.state !== 3'd0 || bus.busy !== 1'b0) $display("FAIL mid_reset: disp %b credit %0d state %0d busy %b want 0 0 0 0", bus.dispense, bus.credit, bus.state, bus.busy); else passed++;
    cyc();
    total++; if (bus.state !== 3'd0 || bus.change_pulse !== 1'b0) $display("FAIL mid_after: state %0d pulse %b want 0 0", bus.state, bus.change_pulse); else passed++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_overpay();
    test_cancel();
    test_saturation();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
